vga_frame_ctrl: RTL and testbench

- Frame scheduler between the VGA timing generator and the game renderer.
- Watches the generator's row/col addresses and turns active-area positions into registered frame-buffer read addresses.
- Detects the start of vertical blank and runs the render handshake with game logic.
- Swaps the double-buffered frame buffers only at vblank, and only once a frame has finished rendering; late frames are counted as drops.

---
 rtl/vga_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_vga_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_ctrl
// Purpose  : Frame scheduler between VGA timing and the renderer; generates
//            frame-buffer read addresses and swaps double buffers at vblank.
// Revision : 1.0
// ============================================================================
module vga_frame_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [11:0]       row_addr,
    input  logic [11:0]       col_addr,
    input  logic              render_done,
    output logic              frame_tick,
    output logic              render_busy,
    output logic              front_sel,
    output logic              back_sel,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);

    localparam logic [11:0]       c_H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0]       c_V_ACT  = 12'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] c_FB_W   = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RENDER = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_tick;
    logic                r_busy;
    logic                r_front;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [15:0]         r_frame_cnt;
    logic [7:0]          r_drop_cnt;

    logic                w_active;
    logic                w_vb_evt;
    logic [11:0]         w_row_s;
    logic [11:0]         w_col_s;
    logic [ADDR_W-1:0]   w_addr;

    assign w_active = (row_addr < c_V_ACT) && (col_addr < c_H_ACT);
    assign w_vb_evt = (row_addr == c_V_ACT) && (col_addr == 12'd0);
    assign w_row_s  = row_addr >> SCALE_SHIFT;
    assign w_col_s  = col_addr >> SCALE_SHIFT;
    // Product deliberately truncated to the frame-buffer address width.
    assign w_addr   = ADDR_W'(w_row_s) * c_FB_W + ADDR_W'(w_col_s);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_front     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_frame_cnt <= 16'd0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_rd_en   <= w_active;
            r_rd_addr <= w_active ? w_addr : '0;
            r_tick    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_vb_evt) begin
                        r_state <= S_RENDER;
                        r_busy  <= 1'b1;
                        r_tick  <= 1'b1;
                    end
                end
                S_RENDER: begin
                    // A completion arriving on the vblank cycle still makes this frame.
                    if (render_done && w_vb_evt) begin
                        r_front     <= ~r_front;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_tick      <= 1'b1;
                    end else if (render_done) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end else if (w_vb_evt) begin
                        if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_vb_evt) begin
                        r_state     <= S_RENDER;
                        r_busy      <= 1'b1;
                        r_front     <= ~r_front;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_tick      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_tick  = r_tick;
    assign render_busy = r_busy;
    assign front_sel   = r_front;
    assign back_sel    = ~r_front;
    assign fb_rd_en    = r_rd_en;
    assign fb_rd_addr  = r_rd_addr;
    assign frame_cnt   = r_frame_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_ctrl
// Purpose  : Self-checking bench for vga_frame_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_vga_frame_ctrl;

    logic        vga_clk;
    logic        rst;
    logic [11:0] row_addr;
    logic [11:0] col_addr;
    logic        render_done;
    logic        frame_tick;
    logic        render_busy;
    logic        front_sel;
    logic        back_sel;
    logic        fb_rd_en;
    logic [16:0] fb_rd_addr;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    vga_frame_ctrl dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .render_done (render_done),
        .frame_tick  (frame_tick),
        .render_busy (render_busy),
        .front_sel   (front_sel),
        .back_sel    (back_sel),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_addr  (fb_rd_addr),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Behavioural model: "started" means the first vblank has been seen,
    // "ready" means the current back buffer has been reported complete.
    bit          m_started;
    bit          m_ready;
    logic        e_tick;
    logic        e_front;
    logic        e_en;
    logic [16:0] e_addr;
    int          e_fcnt;
    int          e_dcnt;

    task automatic model_step(input bit rs, input int r, input int c, input bit d);
        int  a;
        bit  vb;
        bit  act;
        bit  ready_now;
        if (rs) begin
            m_started = 0; m_ready = 0;
            e_tick = 0; e_front = 0; e_en = 0; e_addr = 0;
            e_fcnt = 0; e_dcnt = 0;
        end else begin
            vb  = (r == 480) && (c == 0);
            act = (r < 480) && (c < 640);
            a   = act ? ((r / 2) * 320 + (c / 2)) : 0;
            e_en   = act;
            e_addr = a[16:0];
            e_tick = 0;
            if (!m_started) begin
                if (vb) begin
                    m_started = 1; m_ready = 0; e_tick = 1;
                end
            end else begin
                ready_now = m_ready || d;
                if (vb) begin
                    if (ready_now) begin
                        e_front = ~e_front;
                        e_fcnt  = (e_fcnt + 1) % 65536;
                        e_tick  = 1;
                        m_ready = 0;
                    end else if (e_dcnt < 255) begin
                        e_dcnt = e_dcnt + 1;
                    end
                end else begin
                    m_ready = ready_now;
                end
            end
        end
    endtask

    function automatic logic [45:0] exp_vec();
        logic busy;
        busy = m_started && !m_ready;
        return {e_tick, busy, e_front, ~e_front, e_en, e_addr, e_fcnt[15:0], e_dcnt[7:0]};
    endfunction

    function automatic logic [45:0] act_vec();
        return {frame_tick, render_busy, front_sel, back_sel, fb_rd_en, fb_rd_addr, frame_cnt, drop_cnt};
    endfunction

    task automatic cyc(input logic [11:0] r, input logic [11:0] c, input logic d, input logic rs);
        row_addr = r; col_addr = c; render_done = d; rst = rs;
        @(posedge vga_clk);
        model_step(rs, int'(r), int'(c), d);
        #1;
    endtask

    task automatic idle();
        cyc(12'd500, 12'd800, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(12'd500, 12'd800, 1'b0, 1'b1);
        cyc(12'd500, 12'd800, 1'b0, 1'b1);
        checks++;
        if ({frame_tick, render_busy, front_sel, back_sel, fb_rd_en, fb_rd_addr, frame_cnt, drop_cnt}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", act_vec(),
                     {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 16'd0, 8'd0});
        end
    endtask

    task automatic test_first_tick();
        idle();
        cyc(12'd480, 12'd0, 1'b0, 1'b0);
        checks++;
        if ({frame_tick, render_busy, front_sel, frame_cnt} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL first_tick: got tick=%b busy=%b front=%b fcnt=%0d expected 1 1 0 0",
                     frame_tick, render_busy, front_sel, frame_cnt);
        end
        idle();
        checks++;
        if (frame_tick !== 1'b0 || render_busy !== 1'b1) begin
            errors++;
            $display("FAIL tick_one_cycle: got tick=%b busy=%b expected 0 1", frame_tick, render_busy);
        end
    endtask

    task automatic test_swap();
        cyc(12'd100, 12'd10, 1'b1, 1'b0);
        checks++;
        if (render_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: got %b expected 0", render_busy);
        end
        idle();
        cyc(12'd480, 12'd0, 1'b0, 1'b0);
        checks++;
        if ({front_sel, back_sel, frame_cnt, frame_tick, render_busy} !== {1'b1, 1'b0, 16'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL swap: got front=%b back=%b fcnt=%0d tick=%b busy=%b expected 1 0 1 1 1",
                     front_sel, back_sel, frame_cnt, frame_tick, render_busy);
        end
    endtask

    task automatic test_drops();
        int ticks;
        ticks = 0;
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc(12'd480, 12'd0, 1'b0, 1'b0);
            ticks += int'(frame_tick);
            idle();
        end
        checks++;
        if (drop_cnt !== 8'd3 || front_sel !== 1'b1 || ticks != 0) begin
            errors++;
            $display("FAIL drop3: got drop=%0d front=%b ticks=%0d expected 3 1 0", drop_cnt, front_sel, ticks);
        end
        for (int i = 0; i < 257; i++) begin
            cyc(12'd480, 12'd0, 1'b0, 1'b0);
            ticks += int'(frame_tick);
            idle();
        end
        checks++;
        if (drop_cnt !== 8'd255 || ticks != 0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_sat: got drop=%0d ticks=%0d fcnt=%0d expected 255 0 1", drop_cnt, ticks, frame_cnt);
        end
    endtask

    task automatic test_same_cycle();
        cyc(12'd480, 12'd0, 1'b1, 1'b0);
        checks++;
        if ({front_sel, frame_cnt, drop_cnt, frame_tick, render_busy} !== {1'b0, 16'd2, 8'd255, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL same_cycle: got front=%b fcnt=%0d drop=%0d tick=%b busy=%b expected 0 2 255 1 1",
                     front_sel, frame_cnt, drop_cnt, frame_tick, render_busy);
        end
        idle();
    endtask

    task automatic test_addr();
        logic [11:0] rr [5];
        logic [11:0] cc [5];
        logic [16:0] ea [5];
        logic        ee [5];
        rr = '{12'd3, 12'd479, 12'd3,   12'd4090, 12'd0};
        cc = '{12'd5, 12'd639, 12'd700, 12'd5,    12'd0};
        ea = '{17'd322, 17'd76799, 17'd0, 17'd0, 17'd0};
        ee = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cyc(rr[i], cc[i], 1'b0, 1'b0);
            checks++;
            if (fb_rd_en !== ee[i] || fb_rd_addr !== ea[i]) begin
                errors++;
                $display("FAIL addr_%0d: got en=%b addr=%0d expected en=%b addr=%0d",
                         i, fb_rd_en, fb_rd_addr, ee[i], ea[i]);
            end
        end
    endtask

    task automatic test_reset_in_done();
        cyc(12'd500, 12'd800, 1'b0, 1'b1);
        cyc(12'd480, 12'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(12'd200, 12'd20, 1'b1, 1'b0);
            cyc(12'd480, 12'd0, 1'b0, 1'b0);
        end
        cyc(12'd200, 12'd20, 1'b1, 1'b0);
        checks++;
        if (front_sel !== 1'b1 || frame_cnt !== 16'd7 || render_busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_done: got front=%b fcnt=%0d busy=%b expected 1 7 0",
                     front_sel, frame_cnt, render_busy);
        end
        cyc(12'd480, 12'd0, 1'b0, 1'b1);
        checks++;
        if (act_vec() !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_in_done: got %h expected %h", act_vec(),
                     {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 16'd0, 8'd0});
        end
        idle();
        checks++;
        if (frame_tick !== 1'b0 || render_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vb_no_tick: got tick=%b busy=%b expected 0 0", frame_tick, render_busy);
        end
    endtask

    task automatic test_random();
        logic [11:0] r;
        logic [11:0] c;
        logic        d;
        logic        rs;
        int          sel;
        int          bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                r = 12'd480; c = 12'd0;
            end else if (sel < 7) begin
                r = 12'($urandom_range(0, 479)); c = 12'($urandom_range(0, 639));
            end else begin
                r = 12'($urandom_range(0, 4095)); c = 12'($urandom_range(0, 4095));
            end
            d  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, c, d, rs);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL random_%0d: got %h expected %h (row=%0d col=%0d done=%b rst=%b)",
                             i, act_vec(), exp_vec(), r, c, d, rs);
                end
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; row_addr = 12'd500; col_addr = 12'd800; render_done = 1'b0;
        test_reset();
        test_first_tick();
        test_swap();
        test_drops();
        test_same_cycle();
        test_addr();
        test_reset_in_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
